mem_stall_ctrl: RTL and testbench

MEM_STALL_CTRL -- requirements
Module: Mem_Stall_Ctrl

---
 rtl/mem_stall_ctrl.sv | 100 ++++++++++
 tb/tb_mem_stall_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage load/store sequencer that stalls the pipeline around a ready/rvalid data-memory handshake
module mem_stall_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        Stall_M,
    output logic [31:0] load_data_M,
    output logic        load_valid,
    output logic        Misalign,
    output logic        Timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
    state_t state, state_nx;
    logic access, legal, aligned, go, busy, capture, done_ok, tmo, we_q;
    logic [2:0] f3_q;
    logic [3:0] be_q;
    logic [31:0] addr_q, wdata_q, shifted, load_fmt;
    logic [CW-1:0] cnt;

    assign access = MemRead_M || MemWrite_M;
    assign legal = MemRead_M ? (funct3_M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (funct3_M inside {3'b000, 3'b001, 3'b010});
    assign aligned = (funct3_M[1:0] == 2'b01) ? !addr_M[0]
                   : (funct3_M[1:0] == 2'b10) ? (addr_M[1:0] == 2'b00) : 1'b1;
    assign go = (state == IDLE) && access && legal && aligned;
    assign busy = (state == REQ) || (state == WAIT_RSP);
    assign capture = mem_rvalid && ((state == WAIT_RSP) || ((state == REQ) && mem_ready && !we_q));
    assign done_ok = capture || ((state == REQ) && mem_ready && we_q);
    assign tmo = busy && !done_ok && (cnt == CW'(TIMEOUT - 1));
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    assign load_fmt = (f3_q == 3'b000) ? {{24{shifted[7]}}, shifted[7:0]}
                    : (f3_q == 3'b100) ? {24'b0, shifted[7:0]}
                    : (f3_q == 3'b001) ? {{16{shifted[15]}}, shifted[15:0]}
                    : (f3_q == 3'b101) ? {16'b0, shifted[15:0]} : mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            load_data_M <= '0;
            Timeout_err <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state <= state_nx;
            cnt   <= go ? '0 : busy ? cnt + 1'b1 : cnt;
            if (go) begin
                we_q    <= !MemRead_M;
                f3_q    <= funct3_M;
                addr_q  <= addr_M;
                wdata_q <= (funct3_M[1:0] == 2'b00) ? {4{wdata_M[7:0]}}
                         : (funct3_M[1:0] == 2'b01) ? {2{wdata_M[15:0]}} : wdata_M;
                be_q    <= (funct3_M[1:0] == 2'b00) ? 4'b0001 << addr_M[1:0]
                         : (funct3_M[1:0] == 2'b01) ? 4'b0011 << addr_M[1:0] : 4'b1111;
            end
            if (capture)
                load_data_M <= load_fmt;
            else if (tmo)
                load_data_M <= '0;
            if (tmo)
                Timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = (state == IDLE) ? (go ? REQ : IDLE)
                 : (state == DONE) ? IDLE
                 : (done_ok || tmo) ? DONE
                 : ((state == REQ) && mem_ready) ? WAIT_RSP : state;
    end

    always_comb begin
        mem_req    = rst_n && (state == REQ);
        mem_we     = mem_req && we_q;
        mem_be     = mem_req ? be_q : 4'b0000;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_q;
        Stall_M    = rst_n && (go || busy);
        Misalign   = rst_n && (state == IDLE) && access && !(legal && aligned);
        load_valid = rst_n && (state == DONE) && !we_q;
    end
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;
    localparam int TO = 8;
    logic clk = 1'b0, rst_n;
    logic MemRead_M, MemWrite_M;
    logic [2:0] funct3_M;
    logic [31:0] addr_M, wdata_M;
    logic mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data_M;
    logic [3:0] mem_be;
    logic Stall_M, load_valid, Misalign, Timeout_err;

    int n_chk = 0, n_fail = 0;
    int rdy_dly = 0, rv_dly = 0, req_cnt = 0, pend = 0;
    logic [31:0] rsp_data = '0;
    logic [68:0] exp_req[$];
    logic [31:0] exp_load[$];
    bit exp_mis[$];

    mem_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .funct3_M(funct3_M), .addr_M(addr_M), .wdata_M(wdata_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .Stall_M(Stall_M), .load_data_M(load_data_M), .load_valid(load_valid),
        .Misalign(Misalign), .Timeout_err(Timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // memory responder: ready after rdy_dly REQ cycles, rvalid rv_dly cycles after ready (-1 = never)
    initial begin
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = rsp_data;
            if (mem_req) begin
                if (req_cnt == rdy_dly) begin
                    mem_ready = 1'b1;
                    if (rv_dly == 0) mem_rvalid = 1'b1;
                    else pend = rv_dly;
                end
                req_cnt++;
            end else begin
                req_cnt = 0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) mem_rvalid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_req) begin
            chk("req_expected", exp_req.size() != 0, 1);
            if (exp_req.size() != 0) begin
                chk("req_fields", {mem_we, mem_addr, mem_be, mem_wdata}, exp_req[0]);
                if (mem_ready) void'(exp_req.pop_front());
            end
        end else
            chk("be_idle", mem_be, 0);
        if (load_valid) begin
            chk("load_expected", exp_load.size() != 0, 1);
            if (exp_load.size() != 0) chk("load_data", load_data_M, exp_load.pop_front());
        end
        if (Misalign) begin
            chk("misalign_expected", exp_mis.size() != 0, 1);
            if (exp_mis.size() != 0) void'(exp_mis.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int rdy, input int rv, input logic [31:0] rdat,
                       input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_ld,
                       input int e_stall, input string nm);
        int n = 0;
        rdy_dly = rdy;
        rv_dly = rv;
        rsp_data = rdat;
        exp_req.push_back({!rd, a[31:2], 2'b00, e_be, e_wd});
        if (rd) exp_load.push_back(e_ld);
        MemRead_M = rd;
        MemWrite_M = wr;
        funct3_M = f3;
        addr_M = a;
        wdata_M = wd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!Stall_M) break;
            n++;
            step();
        end
        chk({nm, "_stall"}, n, e_stall);
        step();
        MemRead_M = 1'b0;
        MemWrite_M = 1'b0;
    endtask

    task automatic mis(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input string nm);
        exp_mis.push_back(1'b1);
        MemRead_M = rd;
        MemWrite_M = wr;
        funct3_M = f3;
        addr_M = a;
        @(negedge clk);
        chk({nm, "_stall"}, Stall_M, 0);
        chk({nm, "_req"}, mem_req, 0);
        step();
        MemRead_M = 1'b0;
        MemWrite_M = 1'b0;
        @(negedge clk);
        chk({nm, "_pulse"}, Misalign, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        MemRead_M = 1'b1;
        MemWrite_M = 1'b0;
        funct3_M = 3'b010;
        addr_M = 32'h101;
        wdata_M = '0;
        @(negedge clk);
        chk("rst_misalign", Misalign, 0);
        chk("rst_stall_a", Stall_M, 0);
        step();
        addr_M = 32'h100;
        @(negedge clk);
        chk("rst_stall_b", Stall_M, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_lvalid", load_valid, 0);
        chk("rst_ldata", load_data_M, 0);
        chk("rst_tmo", Timeout_err, 0);
        step();
        MemRead_M = 1'b0;
        rst_n = 1'b1;
        step();

        txn(1, 0, 3'b010, 32'h100, 0, 0, 1, 32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF, 3, "lw");
        txn(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80112233, 4'b1000, 0, 32'hFFFFFF80, 2, "lb");
        txn(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80112233, 4'b1000, 0, 32'h00000080, 2, "lbu");
        txn(1, 0, 3'b001, 32'h102, 0, 0, 0, 32'h80112233, 4'b1100, 0, 32'hFFFF8011, 2, "lh");
        txn(1, 0, 3'b101, 32'h100, 0, 0, 0, 32'h80112233, 4'b0011, 0, 32'h00002233, 2, "lhu");
        txn(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 4, 0, 0, 4'b1100, 32'hABCDABCD, 0, 6, "sh");
        chk("ld_hold", load_data_M, 32'h00002233);
        txn(0, 1, 3'b000, 32'h101, 32'h12345678, 0, 0, 0, 4'b0010, 32'h78787878, 0, 2, "sb");
        txn(0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 0, 3, "sw");
        txn(1, 1, 3'b010, 32'h104, 0, 0, 0, 32'h11223344, 4'b1111, 0, 32'h11223344, 2, "rw_both");

        mis(1, 0, 3'b010, 32'h101, "lw_101");
        mis(1, 0, 3'b001, 32'h103, "lh_103");
        mis(0, 1, 3'b100, 32'h100, "sb_f3_100");
        mis(1, 0, 3'b011, 32'h100, "ld_f3_011");

        txn(1, 0, 3'b010, 32'h180, 0, 0, -1, 32'h77777777, 4'b1111, 0, 32'h0, TO + 1, "timeout");
        chk("tmo_flag", Timeout_err, 1);
        chk("tmo_data", load_data_M, 0);

        rdy_dly = 0;
        rv_dly = 2;
        rsp_data = 32'h55555555;
        exp_req.push_back({1'b0, 32'h300, 4'b1111, 32'h0});
        MemRead_M = 1'b1;
        funct3_M = 3'b010;
        addr_M = 32'h300;
        wdata_M = '0;
        @(negedge clk);
        chk("rr_stall_idle", Stall_M, 1);
        step();
        @(negedge clk);
        chk("rr_req", mem_req, 1);
        step();
        rst_n = 1'b0;
        MemRead_M = 1'b0;
        @(negedge clk);
        chk("rr_stall_rst", Stall_M, 0);
        chk("rr_req_rst", mem_req, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_rvalid_seen", mem_rvalid, 1);
        chk("rr_lvalid", load_valid, 0);
        chk("rr_ldata", load_data_M, 0);
        chk("rr_tmo_clr", Timeout_err, 0);
        chk("rr_stall_after", Stall_M, 0);
        step();
        @(negedge clk);
        chk("rr_lvalid2", load_valid, 0);
        chk("rr_ldata2", load_data_M, 0);
        step();

        txn(1, 0, 3'b010, 32'h400, 0, 0, 0, 32'h0BADF00D, 4'b1111, 0, 32'h0BADF00D, 2, "recover");
        repeat (2) step();
        chk("q_req_empty", exp_req.size(), 0);
        chk("q_load_empty", exp_load.size(), 0);
        chk("q_mis_empty", exp_mis.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
